// File: rtl/bf16_pkg.sv
// Shared BF16 definitions for the floating-point unit: field widths, constants,
// operand classes, status-flag bundle and the divider FSM states.
package bf16_pkg;

  localparam int unsigned BF16_W = 16;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 7;
  localparam logic [7:0]  BIAS   = 8'd127;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_PINF = 16'h7F80;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    NORMAL = 3'd1,
    INF    = 3'd2,
    QNAN   = 3'd3,
    SNAN   = 3'd4
  } bf16_class_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } div_state_e;

  typedef struct packed {
    logic zero;
    logic underflow;
    logic overflow;
    logic q_nan;
    logic s_nan;
    logic positive_inf;
    logic negative_inf;
    logic div_by_zero;
  } bf16_flags_t;

  localparam bf16_flags_t FLAGS_CLEAR = bf16_flags_t'(8'h00);

  function automatic logic [15:0] signed_inf(input logic sign);
    return {sign, BF16_PINF[14:0]};
  endfunction

endpackage

// File: rtl/bf16_divider_if.sv
// Operand/result handshake bundle of the BF16 divider; master = producer and
// consumer side, slave = the divider.
interface bf16_divider_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] num_1;
  logic [15:0] num_2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        underflow;
  logic        overflow;
  logic        q_nan;
  logic        s_nan;
  logic        positive_inf;
  logic        negative_inf;
  logic        div_by_zero;

  modport master (
    output in_valid, num_1, num_2, out_ready,
    input  in_ready, out_valid, result, zero, underflow, overflow,
           q_nan, s_nan, positive_inf, negative_inf, div_by_zero
  );

  modport slave (
    input  in_valid, num_1, num_2, out_ready,
    output in_ready, out_valid, result, zero, underflow, overflow,
           q_nan, s_nan, positive_inf, negative_inf, div_by_zero
  );

endinterface

// File: rtl/bf16_classify.sv
// Combinational BF16 operand classifier (zero / normal / inf / qNaN / sNaN);
// exponent 0 is treated as zero since subnormals are not supported.
module bf16_classify
  import bf16_pkg::*;
(
  input  logic [15:0] operand,
  output bf16_class_e op_class
);

  logic [EXP_W-1:0]  exp_s;
  logic [MANT_W-1:0] mant_s;
  logic              unused_sign_s;

  assign exp_s         = operand[MANT_W +: EXP_W];
  assign mant_s        = operand[0 +: MANT_W];
  assign unused_sign_s = operand[15];

  // Decode the operand class from exponent and mantissa fields.
  always_comb begin
    op_class = NORMAL;
    if (exp_s == 8'h00) begin
      op_class = ZERO;
    end else if (exp_s == 8'hFF) begin
      if (mant_s == 7'h00) begin
        op_class = INF;
      end else if (mant_s[6]) begin
        op_class = QNAN;
      end else begin
        op_class = SNAN;
      end
    end else begin
      op_class = NORMAL;
    end
  end

endmodule

// File: rtl/bf16_divider.sv
// Sequential BF16 divider: restoring radix-2 mantissa division, one quotient bit
// per cycle. Define BF16_DIV_ROUND_EN for round-to-nearest-even, else truncation.
module bf16_divider
  import bf16_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  bf16_divider_if.slave  bus
);

`ifdef BF16_DIV_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  div_state_e         state_r, next_state_s;
  bf16_class_e        cls_1_s, cls_2_s;
  logic               sign_s;
  logic               special_s;
  logic [15:0]        spec_result_s;
  bf16_flags_t        spec_flags_s;

  logic               in_ready_r;
  logic               out_valid_r;
  logic [15:0]        result_r;
  bf16_flags_t        flags_r;
  logic               sign_r;
  logic signed [9:0]  exp_base_r;
  logic [8:0]         rem_r;
  logic [7:0]         div_r;
  logic [9:0]         quo_r;
  logic [3:0]         cnt_r;

  logic               rem_ge_s;
  logic [8:0]         rem_sub_s;
  logic [8:0]         rem_step_s;

  logic [6:0]         mant_s;
  logic               guard_s;
  logic               sticky_s;
  logic signed [9:0]  exp_s;
  logic               round_up_s;
  logic [7:0]         mant_inc_s;
  logic [6:0]         mant_fin_s;
  logic signed [9:0]  exp_rnd_s;
  logic [15:0]        norm_result_s;
  bf16_flags_t        norm_flags_s;

  bf16_classify u_cls_1 (.operand(bus.num_1), .op_class(cls_1_s));
  bf16_classify u_cls_2 (.operand(bus.num_2), .op_class(cls_2_s));

  assign sign_s = bus.num_1[15] ^ bus.num_2[15];

  // Special-operand results, evaluated on the live inputs at the accept edge.
  always_comb begin
    special_s     = 1'b1;
    spec_result_s = 16'h0000;
    spec_flags_s  = FLAGS_CLEAR;
    if ((cls_1_s == SNAN) || (cls_2_s == SNAN)) begin
      spec_result_s      = BF16_QNAN;
      spec_flags_s.s_nan = 1'b1;
    end else if ((cls_1_s == QNAN) || (cls_2_s == QNAN) ||
                 ((cls_1_s == INF) && (cls_2_s == INF)) ||
                 ((cls_1_s == ZERO) && (cls_2_s == ZERO))) begin
      spec_result_s      = BF16_QNAN;
      spec_flags_s.q_nan = 1'b1;
    end else if (cls_1_s == INF) begin
      spec_result_s             = signed_inf(sign_s);
      spec_flags_s.positive_inf = ~sign_s;
      spec_flags_s.negative_inf = sign_s;
    end else if (cls_2_s == ZERO) begin
      spec_result_s             = signed_inf(sign_s);
      spec_flags_s.positive_inf = ~sign_s;
      spec_flags_s.negative_inf = sign_s;
      spec_flags_s.div_by_zero  = 1'b1;
    end else if ((cls_1_s == ZERO) || (cls_2_s == INF)) begin
      spec_result_s     = {sign_s, 15'h0000};
      spec_flags_s.zero = 1'b1;
    end else begin
      special_s = 1'b0;
    end
  end

  // One restoring step; the partial remainder always stays below twice the divisor.
  assign rem_ge_s   = (rem_r >= {1'b0, div_r});
  assign rem_sub_s  = rem_r - {1'b0, div_r};
  assign rem_step_s = rem_ge_s ? {rem_sub_s[7:0], 1'b0} : {rem_r[7:0], 1'b0};

  // Normalise the 10-bit quotient, round, and range-check the exponent.
  always_comb begin
    if (quo_r[9]) begin
      mant_s   = quo_r[8:2];
      guard_s  = quo_r[1];
      sticky_s = quo_r[0] | (rem_r != 9'd0);
      exp_s    = exp_base_r;
    end else begin
      mant_s   = quo_r[7:1];
      guard_s  = quo_r[0];
      sticky_s = (rem_r != 9'd0);
      exp_s    = exp_base_r - 10'sd1;
    end
    round_up_s = ROUND_EN & guard_s & (sticky_s | mant_s[0]);
    mant_inc_s = {1'b0, mant_s} + {7'd0, round_up_s};
    if (mant_inc_s[7]) begin
      exp_rnd_s  = exp_s + 10'sd1;
      mant_fin_s = 7'h00;
    end else begin
      exp_rnd_s  = exp_s;
      mant_fin_s = mant_inc_s[6:0];
    end
    norm_flags_s = FLAGS_CLEAR;
    if (exp_rnd_s >= 10'sd255) begin
      norm_result_s             = signed_inf(sign_r);
      norm_flags_s.overflow     = 1'b1;
      norm_flags_s.positive_inf = ~sign_r;
      norm_flags_s.negative_inf = sign_r;
    end else if (exp_rnd_s <= 10'sd0) begin
      norm_result_s          = {sign_r, 15'h0000};
      norm_flags_s.underflow = 1'b1;
      norm_flags_s.zero      = 1'b1;
    end else begin
      norm_result_s = {sign_r, exp_rnd_s[7:0], mant_fin_s};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          next_state_s = special_s ? DONE : DIVIDE;
        end else begin
          next_state_s = IDLE;
        end
      end
      DIVIDE: begin
        if (cnt_r == 4'd9) begin
          next_state_s = NORM;
        end else begin
          next_state_s = DIVIDE;
        end
      end
      NORM: next_state_s = DONE;
      DONE: begin
        if (out_valid_r && bus.out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Operand capture, divider iterations and registered result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= 16'h0000;
      flags_r     <= FLAGS_CLEAR;
      sign_r      <= 1'b0;
      exp_base_r  <= 10'sd0;
      rem_r       <= 9'd0;
      div_r       <= 8'd0;
      quo_r       <= 10'd0;
      cnt_r       <= 4'd0;
    end else begin
      in_ready_r <= (next_state_s == IDLE);
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            sign_r     <= sign_s;
            exp_base_r <= $signed({2'b00, bus.num_1[14:7]}) - $signed({2'b00, bus.num_2[14:7]})
                          + $signed({2'b00, BIAS});
            rem_r      <= {2'b01, bus.num_1[6:0]};
            div_r      <= {1'b1, bus.num_2[6:0]};
            quo_r      <= 10'd0;
            cnt_r      <= 4'd0;
            if (special_s) begin
              result_r <= spec_result_s;
              flags_r  <= spec_flags_s;
            end
          end
        end
        DIVIDE: begin
          rem_r <= rem_step_s;
          quo_r <= {quo_r[8:0], rem_ge_s};
          cnt_r <= cnt_r + 4'd1;
        end
        NORM: begin
          result_r <= norm_result_s;
          flags_r  <= norm_flags_s;
        end
        DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.result       = result_r;
  assign bus.zero         = flags_r.zero;
  assign bus.underflow    = flags_r.underflow;
  assign bus.overflow     = flags_r.overflow;
  assign bus.q_nan        = flags_r.q_nan;
  assign bus.s_nan        = flags_r.s_nan;
  assign bus.positive_inf = flags_r.positive_inf;
  assign bus.negative_inf = flags_r.negative_inf;
  assign bus.div_by_zero  = flags_r.div_by_zero;

endmodule
